// File: rtl/rr_timed_arbiter.sv
// Round-robin arbiter over NPORTS requesters; each port's grant is bounded by
// a per-port length timer loaded from header flits.
module rr_timed_arbiter #(
    parameter int                NPORTS  = 5,
    parameter int                LEN_W   = 12,
    parameter int                FID_W   = 3,
    parameter logic [FID_W-1:0]  HEAD_ID = 3'b001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       req,
    input  logic [NPORTS*FID_W-1:0] flit_id,
    input  logic [NPORTS*LEN_W-1:0] length,
    output logic [NPORTS-1:0]       grant,
    output logic                    grant_valid,
    output logic [NPORTS-1:0]       timeout
);
    localparam int PTR_W = $clog2(NPORTS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PTR_W-1:0]  last_r;
    logic [PTR_W-1:0]  last_s;
    logic [NPORTS-1:0] grant_r;
    logic [NPORTS-1:0] grant_s;
    logic              grant_valid_r;
    logic [NPORTS-1:0] timeout_r;
    logic [NPORTS-1:0] timeout_s;
    logic [NPORTS-1:0] scan_req_s;
    logic              pick_found_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic [NPORTS-1:0] timesup_s;
    logic [LEN_W-1:0]  count_r [NPORTS];
    logic [LEN_W-1:0]  limit_r [NPORTS];

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(NPORTS)) begin
            sum = sum - (PTR_W+1)'(NPORTS);
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign timeout     = timeout_r;

    // While granted, the holder is excluded so it cannot be re-granted directly.
    assign scan_req_s = (state_r == S_GRANT) ? (req & ~grant_r) : req;

    // Timer expiry per port.
    always_comb begin
        timesup_s = '0;
        for (int i = 0; i < NPORTS; i++) begin
            timesup_s[i] = (count_r[i] == limit_r[i]);
        end
    end

    // Round-robin pick: farthest offset first so the nearest requester after last wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int off = NPORTS; off >= 1; off--) begin
            if (scan_req_s[wrap_idx(last_r, off)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = wrap_idx(last_r, off);
            end else begin
                pick_found_s = pick_found_s;
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Next state, next pointer and next registered outputs.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        grant_s   = '0;
        timeout_s = '0;
        case (state_r)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_s = S_GRANT;
                    last_s  = pick_idx_s;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GRANT: begin
                if (req[last_r] && !timesup_s[last_r]) begin
                    state_s = S_GRANT;
                end else begin
                    // Still requesting here means the timer forced the release.
                    timeout_s[last_r] = req[last_r];
                    if (pick_found_s) begin
                        last_s = pick_idx_s;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        grant_s[last_s] = (state_s == S_GRANT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            last_r        <= PTR_W'(NPORTS - 1);
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            timeout_r     <= '0;
        end else begin
            state_r       <= state_s;
            last_r        <= last_s;
            grant_r       <= grant_s;
            grant_valid_r <= |grant_s;
            timeout_r     <= timeout_s;
        end
    end

    // Per-port hold counters and header-loaded limits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                count_r[i] <= '0;
                limit_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (grant_r[i] && grant_s[i]) begin
                    if (count_r[i] != '1) begin
                        count_r[i] <= count_r[i] + LEN_W'(1);
                    end else begin
                        count_r[i] <= count_r[i];
                    end
                end else begin
                    count_r[i] <= '0;
                end
                if (flit_id[i*FID_W +: FID_W] == HEAD_ID) begin
                    limit_r[i] <= length[i*LEN_W +: LEN_W];
                end else begin
                    limit_r[i] <= limit_r[i];
                end
            end
        end
    end

endmodule
